// File: rtl/vram_loader.sv
`default_nettype none
// ============================================================================
// Module   : vram_loader
// Purpose  : Command-driven sequencer for the video_core VRAM write port.
//            Decodes a three-byte command stream from the UART receiver
//            (ADDR 0x01, DATA 0x02, FILL 0x03) and is the only master of
//            the VRAM write port. An optional fill engine paints the whole
//            VRAM with one pattern; host DATA writes win over fill writes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   VRAM_LOADER_FILL_EN  defined   -> fill engine and FILL command present
//                        undefined -> no fill logic, 0x03 ignored,
//                                     o_fill_busy tied low
// ----------------------------------------------------------------------------
// Ports:
//   i_clk          in   1   system clock (same clock as the VRAM write port)
//   i_rst_n        in   1   asynchronous active-low reset
//   i_rx_data      in   8   received byte
//   i_rx_valid     in   1   one-cycle strobe qualifying i_rx_data
//   o_vram_data    out  16  registered write data
//   o_vram_wraddr  out  AW  registered write address
//   o_vram_wren    out  1   registered write enable, one cycle per word
//   o_ptr          out  AW  current host write pointer
//   o_fill_busy    out  1   fill engine has words left to write
// ============================================================================
module vram_loader #(
    parameter int WORDS = 600,
    parameter int AW    = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_valid,
    output logic [15:0]   o_vram_data,
    output logic [AW-1:0] o_vram_wraddr,
    output logic          o_vram_wren,
    output logic [AW-1:0] o_ptr,
    output logic          o_fill_busy
);

    typedef enum logic [1:0] {
        S_CMD    = 2'd0,
        S_ARG_HI = 2'd1,
        S_ARG_LO = 2'd2
    } state_t;

    localparam logic [1:0]    c_CMD_ADDR = 2'd1;
    localparam logic [1:0]    c_CMD_DATA = 2'd2;
    localparam logic [AW-1:0] c_PTR_LAST = AW'(WORDS - 1);
`ifdef VRAM_LOADER_FILL_EN
    localparam logic [1:0]    c_CMD_FILL = 2'd3;
    // Counter is one bit wider than the address so it can hold WORDS itself.
    localparam logic [AW:0]   c_FILL_END = (AW+1)'(WORDS);
`endif

    // Parser and host-side state
    state_t        r_state;
    logic [1:0]    r_cmd;
    logic [7:0]    r_hi;
    logic [AW-1:0] r_ptr;

    // Registered VRAM write port
    logic          r_wren;
    logic [15:0]   r_data;
    logic [AW-1:0] r_wraddr;

`ifdef VRAM_LOADER_FILL_EN
    logic          r_fill_busy;
    logic [AW:0]   r_fill_cnt;     // next fill address to write
    logic [15:0]   r_fill_pat;
`endif

    logic [15:0]   w_arg;
    logic [AW-1:0] w_arg_addr;
    logic          w_arg_oor;
    logic          w_exec;
    logic          w_host_wr;
    logic [AW-1:0] w_ptr_next;
    logic          w_cmd_ok;
    logic [1:0]    w_cmd_sel;

    assign w_arg      = {r_hi, i_rx_data};
    assign w_arg_addr = w_arg[AW-1:0];
    assign w_arg_oor  = (32'(w_arg_addr) >= 32'(WORDS));
    assign w_exec     = i_rx_valid && (r_state == S_ARG_LO);
    // A host write is registered in the ARG_LO cycle, so it owns the port
    // in the following cycle; the fill engine yields that same edge.
    assign w_host_wr  = w_exec && (r_cmd == c_CMD_DATA);
    assign w_ptr_next = (r_ptr == c_PTR_LAST) ? '0 : (r_ptr + AW'(1));

    // Command byte decode; anything unrecognised keeps the parser in CMD.
    always_comb begin
        w_cmd_ok  = 1'b0;
        w_cmd_sel = c_CMD_ADDR;
        case (i_rx_data)
            8'h01: begin
                w_cmd_ok  = 1'b1;
                w_cmd_sel = c_CMD_ADDR;
            end
            8'h02: begin
                w_cmd_ok  = 1'b1;
                w_cmd_sel = c_CMD_DATA;
            end
`ifdef VRAM_LOADER_FILL_EN
            8'h03: begin
                w_cmd_ok  = 1'b1;
                w_cmd_sel = c_CMD_FILL;
            end
`endif
            default: begin
                w_cmd_ok  = 1'b0;
                w_cmd_sel = c_CMD_ADDR;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_CMD;
            r_cmd       <= c_CMD_ADDR;
            r_hi        <= 8'h00;
            r_ptr       <= '0;
            r_wren      <= 1'b0;
            r_data      <= 16'h0000;
            r_wraddr    <= '0;
`ifdef VRAM_LOADER_FILL_EN
            r_fill_busy <= 1'b0;
            r_fill_cnt  <= '0;
            r_fill_pat  <= 16'h0000;
`endif
        end else begin
            r_wren <= 1'b0;

            // Byte parser: advances only on strobed bytes.
            if (i_rx_valid) begin
                case (r_state)
                    S_CMD: begin
                        if (w_cmd_ok) begin
                            r_cmd   <= w_cmd_sel;
                            r_state <= S_ARG_HI;
                        end
                    end
                    S_ARG_HI: begin
                        r_hi    <= i_rx_data;
                        r_state <= S_ARG_LO;
                    end
                    S_ARG_LO: begin
                        r_state <= S_CMD;
                    end
                    default: begin
                        r_state <= S_CMD;
                    end
                endcase
            end

`ifdef VRAM_LOADER_FILL_EN
            // Fill engine. Written before command execution so that a host
            // DATA or a restarting FILL below overrides it on the same edge.
            if (r_fill_busy) begin
                if (r_fill_cnt == c_FILL_END) begin
                    r_fill_busy <= 1'b0;
                end else if (!w_host_wr) begin
                    r_wren     <= 1'b1;
                    r_data     <= r_fill_pat;
                    r_wraddr   <= r_fill_cnt[AW-1:0];
                    r_fill_cnt <= r_fill_cnt + (AW+1)'(1);
                end
            end
`endif

            if (w_exec) begin
                case (r_cmd)
                    c_CMD_ADDR: begin
                        r_ptr <= w_arg_oor ? '0 : w_arg_addr;
                    end
                    c_CMD_DATA: begin
                        r_wren   <= 1'b1;
                        r_data   <= w_arg;
                        r_wraddr <= r_ptr;
                        r_ptr    <= w_ptr_next;
                    end
`ifdef VRAM_LOADER_FILL_EN
                    c_CMD_FILL: begin
                        // Word 0 is issued straight away so the first fill
                        // write appears together with the busy flag; the
                        // counter therefore resumes at 1. Restarting an
                        // active fill simply lands here again.
                        r_fill_pat  <= w_arg;
                        r_fill_busy <= 1'b1;
                        r_fill_cnt  <= (AW+1)'(1);
                        r_wren      <= 1'b1;
                        r_data      <= w_arg;
                        r_wraddr    <= '0;
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_vram_data   = r_data;
    assign o_vram_wraddr = r_wraddr;
    assign o_vram_wren   = r_wren;
    assign o_ptr         = r_ptr;
`ifdef VRAM_LOADER_FILL_EN
    assign o_fill_busy   = r_fill_busy;
`else
    assign o_fill_busy   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_loader
// Purpose  : Self-checking bench for vram_loader. Drives directed and
//            randomized command streams and compares the write port and
//            pointer against a command-level reference model. Fill scenarios
//            are exercised when VRAM_LOADER_FILL_EN is defined; otherwise the
//            bench checks that 0x03 is ignored and o_fill_busy stays low.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_loader;

    localparam int WORDS = 600;
    localparam int AW    = 10;
`ifdef VRAM_LOADER_FILL_EN
    localparam bit FILL_ON = 1'b1;
`else
    localparam bit FILL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [15:0]   o_data;
    logic [AW-1:0] o_wraddr;
    logic          o_wren;
    logic [AW-1:0] o_ptr;
    logic          o_busy;

    always #5 clk = ~clk;

    vram_loader #(.WORDS(WORDS), .AW(AW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .o_vram_data   (o_data),
        .o_vram_wraddr (o_wraddr),
        .o_vram_wren   (o_wren),
        .o_ptr         (o_ptr),
        .o_fill_busy   (o_busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;
    wr_t wr_q[$];
    int  wr_count = 0;

    // Reference model state: host pointer and number of host writes expected.
    int m_ptr = 0;
    int m_writes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Write monitor: records every write with its cycle stamp.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (o_wren === 1'b1) begin
                wr_count++;
                wr_q.push_back('{a: int'(o_wraddr), d: int'(o_data), c: cyc});
                check("wraddr_in_range", 32'(int'(o_wraddr) < WORDS), 32'd1);
            end
`ifndef VRAM_LOADER_FILL_EN
            check("fill_busy_tied_low", 32'(o_busy), 32'd0);
`endif
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int model_addr(input int arg);
        int v;
        v = arg % (1 << AW);
        return (v >= WORDS) ? 0 : v;
    endfunction

    function automatic logic [7:0] rand_garbage();
        logic [7:0] b;
        do begin
            b = 8'($urandom_range(0, 255));
        end while (b == 8'h01 || b == 8'h02 || (FILL_ON && b == 8'h03));
        return b;
    endfunction

    task automatic do_addr(input logic [15:0] arg);
        send(8'h01);
        send(arg[15:8]);
        send(arg[7:0]);
        m_ptr = model_addr(int'(arg));
        check("addr_ptr", 32'(o_ptr), 32'(m_ptr));
        if (o_busy !== 1'b1) check("addr_no_write", 32'(o_wren), 32'd0);
    endtask

    task automatic do_data(input logic [15:0] arg);
        int old;
        old = m_ptr;
        send(8'h02);
        send(arg[15:8]);
        send(arg[7:0]);
        m_ptr = (m_ptr + 1) % WORDS;
        m_writes++;
        check("data_wren", 32'(o_wren), 32'd1);
        check("data_wraddr", 32'(o_wraddr), 32'(old));
        check("data_wdata", 32'(o_data), 32'(arg));
        check("data_ptr", 32'(o_ptr), 32'(m_ptr));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wren"}, 32'(o_wren), 32'd0);
        check({tag, "_data"}, 32'(o_data), 32'd0);
        check({tag, "_wraddr"}, 32'(o_wraddr), 32'd0);
        check({tag, "_ptr"}, 32'(o_ptr), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

`ifdef VRAM_LOADER_FILL_EN
    // Number of fill-pattern writes in the log if they cover 0,1,2,... in
    // order with no gap or repeat; -1 otherwise.
    function automatic int fill_seq(input int pat);
        int k;
        k = 0;
        foreach (wr_q[i]) begin
            if (wr_q[i].d == pat) begin
                if (wr_q[i].a != k) return -1;
                k++;
            end
        end
        return k;
    endfunction

    function automatic int count_data(input int pat);
        int k;
        k = 0;
        foreach (wr_q[i]) if (wr_q[i].d == pat) k++;
        return k;
    endfunction

    // Waits (bounded) for the fill to finish; returns cycles elapsed since c0.
    task automatic wait_fill(input int c0, output int span);
        int guard;
        guard = 0;
        while (o_busy === 1'b1 && guard < 3000) begin
            guard++;
            @(posedge clk);
            #1;
        end
        check("fill_done_in_time", 32'(guard < 3000), 32'd1);
        span = cyc - c0;
    endtask
`endif

    int n0;
    int c0;
    int span;
    int k;
    int sel;
    logic [15:0] arg;

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        idle(3);
        check_reset_outputs("reset_hold");
        rst_n = 1'b1;
        idle(2);
        check_reset_outputs("after_release");

        // ---------------- asynchronous reset mid-command ----------------
        do_data(16'hBEEF);
        send(8'h02);
        send(8'h12);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ptr = 0;
        n0 = wr_count;
        do_data(16'h1234);
        idle(2);
        check("post_reset_one_write", 32'(wr_count - n0), 32'd1);

        // ---------------- addressing and wrap ----------------
        do_addr(16'h0257);
        do_data(16'hABCD);
        do_data(16'hABCD);
        check("wrap_ptr_is_1", 32'(o_ptr), 32'd1);
        do_addr(16'h03FF);
        check("oor_ptr_is_0", 32'(o_ptr), 32'd0);
        do_addr(16'hFC05);
        check("hi_bits_ignored_ptr", 32'(o_ptr), 32'd5);

        // ---------------- garbage bytes ----------------
        n0 = wr_count;
        send(8'h7F);
        send(8'h00);
        do_data(16'h1122);
        idle(2);
        check("garbage_one_write", 32'(wr_count - n0), 32'd1);
        check("garbage_last_data", 32'(wr_q[wr_q.size()-1].d), 32'h1122);

        // ---------------- randomized command mix ----------------
        n0 = wr_count;
        m_writes = 0;
        for (int it = 0; it < 80; it++) begin
            sel = int'($urandom_range(0, 2));
            arg = 16'($urandom);
            if (sel == 0) begin
                do_addr(arg);
            end else if (sel == 1) begin
                do_data(arg);
            end else begin
                k = int'($urandom_range(1, 3));
                for (int g = 0; g < k; g++) send(rand_garbage());
                check("rand_garbage_ptr", 32'(o_ptr), 32'(m_ptr));
            end
            idle(int'($urandom_range(0, 2)));
        end
        idle(2);
        check("rand_write_count", 32'(wr_count - n0), 32'(m_writes));

`ifdef VRAM_LOADER_FILL_EN
        // ---------------- plain fill ----------------
        do_addr(16'd77);
        wr_q.delete();
        send(8'h03);
        send(8'hFF);
        send(8'hFF);
        c0 = cyc;
        check("fill_busy_at_t1", 32'(o_busy), 32'd1);
        wait_fill(c0, span);
        idle(1);
        check("fill_busy_cycles", 32'(span), 32'd600);
        check("fill_write_count", 32'(wr_q.size()), 32'd600);
        check("fill_seq", 32'(fill_seq(32'hFFFF)), 32'd600);
        check("fill_consecutive", 32'(wr_q[wr_q.size()-1].c - wr_q[0].c), 32'd599);
        check("fill_ptr_unchanged", 32'(o_ptr), 32'd77);

        // ---------------- arbitration ----------------
        do_addr(16'd5);
        wr_q.delete();
        send(8'h03);
        send(8'h13);
        send(8'h57);
        c0 = cyc;
        idle(int'($urandom_range(20, 200)));
        do_data(16'h000F);
        wait_fill(c0, span);
        idle(1);
        check("arb_busy_cycles", 32'(span), 32'd601);
        check("arb_fill_seq", 32'(fill_seq(32'h1357)), 32'd600);
        check("arb_host_count", 32'(count_data(32'h000F)), 32'd1);
        check("arb_total_writes", 32'(wr_q.size()), 32'd601);
        check("arb_ptr", 32'(o_ptr), 32'd6);

        // ---------------- fill restart ----------------
        wr_q.delete();
        send(8'h03);
        send(8'h55);
        send(8'h55);
        k = int'($urandom_range(50, 300));
        idle(k);
        send(8'h03);
        send(8'hAA);
        send(8'hAA);
        c0 = cyc;
        check("restart_wren", 32'(o_wren), 32'd1);
        check("restart_addr0", 32'(o_wraddr), 32'd0);
        check("restart_data", 32'(o_data), 32'hAAAA);
        wait_fill(c0, span);
        idle(1);
        check("restart_busy_cycles", 32'(span), 32'd600);
        check("restart_new_seq", 32'(fill_seq(32'hAAAA)), 32'd600);
        check("restart_old_count", 32'(count_data(32'h5555)), 32'(k + 3));
        check("restart_old_seq", 32'(fill_seq(32'h5555)), 32'(k + 3));
        check("restart_ptr", 32'(o_ptr), 32'd6);
`else
        // ---------------- 0x03 ignored without fill ----------------
        n0 = wr_count;
        send(8'h03);
        check("no_fill_busy", 32'(o_busy), 32'd0);
        do_data(16'h1122);
        idle(2);
        check("no_fill_one_write", 32'(wr_count - n0), 32'd1);
        check("no_fill_last_data", 32'(wr_q[wr_q.size()-1].d), 32'h1122);
`endif

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/vram_loader.md
# vram_loader

Command-driven sequencer for the VRAM write port (`VRAM_DATA` / `VRAM_WRADDR` / `VRAM_WREN`) of `video_core`.
- Consumes a byte stream from the UART receiver and decodes a three-command protocol: set address, write word, fill screen.
- Drives every VRAM write; the VRAM write port has no other master.
- Contains a fill engine that shares the write port with host word writes. Host writes have fixed priority over fill.

## Interface
Parameters:
- `WORDS`, 600 — number of VRAM words: 80×60 cells at 8 cells per word.
- `AW`, 10 — VRAM address width.

Ports:
- `CLK`  in  1  system clock; the same clock as the VRAM write port.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `RX_DATA`  in  8  received byte.
- `RX_VALID`  in  1  one-cycle strobe; `RX_DATA` is valid in that cycle. There is no backpressure.
- `VRAM_DATA`  out  16  write data, registered.
- `VRAM_WRADDR`  out  AW  write address, registered.
- `VRAM_WREN`  out  1  write enable, registered, one cycle per word.
- `PTR`  out  AW  current host write pointer.
- `FILL_BUSY`  out  1  high while the fill engine has words left to write.

## Operation
- Parser states: `CMD`, `ARG_HI`, `ARG_LO`. State only advances on a cycle with `RX_VALID`.
- In `CMD`, byte `0x01` selects ADDR, `0x02` selects DATA, `0x03` selects FILL. Any other byte is ignored and the parser stays in `CMD`.
- `ARG_HI` latches the byte into `hi`. `ARG_LO` executes the selected command using `{hi, RX_DATA}` and returns to `CMD`.
- **ADDR:** `PTR` ← `{hi[1:0], lo}`. If that value is ≥ `WORDS`, `PTR` ← 0.
- **DATA:** issues a write of `{hi, lo}` to `PTR`. `PTR` then increments, and wraps from `WORDS-1` to 0.
- **FILL:** latches the pattern `{hi, lo}` and sets the fill counter to 0. Sets `FILL_BUSY`.
  - The engine writes the pattern to addresses 0..`WORDS-1`, one word per granted cycle, then clears `FILL_BUSY`.
  - The fill does not modify `PTR`.
- **Arbitration:**
  - A DATA write is granted in the cycle following its `ARG_LO` byte.
  - In that cycle the fill engine stalls: its counter is held and it performs no write.
  - In every other cycle the fill engine writes while `FILL_BUSY` is high.
- **FILL while `FILL_BUSY`:** restarts from address 0 with the new pattern. The old fill is abandoned.
- **Reset values:** `VRAM_WREN`=0, `VRAM_DATA`=0, `VRAM_WRADDR`=0, `PTR`=0, `FILL_BUSY`=0. Parser state is `CMD`, `hi`=0, fill counter 0.
- **Reset mid-command or mid-fill:** the partial command is discarded, the fill is aborted, and VRAM contents are left as they are.

## Timing
- Cycle t is the cycle in which the `ARG_LO` byte is strobed.
- **DATA:** `VRAM_WREN`=1 at t+1, with `VRAM_WRADDR` = old `PTR`. `PTR` shows the incremented value at t+1.
- **ADDR:** `PTR` shows the new value at t+1. No write occurs.
- **FILL:** `FILL_BUSY`=1 from t+1. Writes to addresses 0..599 occur at t+1..t+600 when there are no stalls. `FILL_BUSY`=0 at t+601.
  - Each granted DATA write during the fill delays fill completion by 1 cycle.
- **Consecutive commands:** back-to-back `RX_VALID` on every cycle is legal. Each command then takes 3 cycles, so at most one DATA write per 3 cycles, and a fill is never starved.
- `VRAM_WREN` is never high for more than one write per cycle. `VRAM_WRADDR` is always < `WORDS` whenever `VRAM_WREN` is high.

## Configuration
- **`VRAM_LOADER_FILL_EN` defined:** the fill engine and the FILL command are compiled in, as described above.
- **`VRAM_LOADER_FILL_EN` undefined:**
  - No fill logic is present.
  - `0x03` is treated as an unknown byte in `CMD` and ignored.
  - `FILL_BUSY` is tied to 0.
  - DATA and ADDR behaviour and timing are unchanged.

## Test plan
- **Reset:** assert `RST_N`=0 asynchronously mid-stream.
  - During reset, all outputs are 0 immediately.
  - After release, bytes `0x02 0x12 0x34` produce a write of 0x1234 to address 0; `PTR` then reads 1.
- **Addressing and wrap:** send `0x01 0x02 0x57` (599), then `0x02 0xAB 0xCD` twice.
  - Required writes: 0xABCD to address 599, then to address 0. `PTR` then reads 1.
  - Send `0x01 0x03 0xFF` (1023): `PTR` reads 0.
- **Fill:** send `0x03 0xFF 0xFF`.
  - Exactly 600 writes of 0xFFFF to addresses 0..599, on consecutive cycles.
  - `FILL_BUSY` is high for exactly 600 cycles. `PTR` is unchanged.
- **Arbitration:** during a fill, complete `0x02 0x00 0x0F` with `PTR`=5.
  - The host write of 0x000F to address 5 occurs in the next cycle.
  - The fill address holds for that cycle, no fill address is skipped, and `FILL_BUSY` lasts 601 cycles.
- **Fill restart:** in the middle of a fill of 0x5555, send `0x03 0xAAAA`.
  - The next fill write is 0xAAAA to address 0, followed by 600 total 0xAAAA writes.
- **Garbage bytes:** send `0x7F 0x00 0x02 0x11 0x22`.
  - Exactly one write, 0x1122, occurs.
  - With `VRAM_LOADER_FILL_EN` undefined, the sequence `0x03 0x02 0x11 0x22` also yields exactly one write, 0x1122, and `FILL_BUSY` stays 0.
